// File: rtl/fwd_stall_ctrl_pkg.sv
// Shared pipeline package: forward-select encodings and
// the multi-cycle tracker state enum.
package fwd_stall_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_e;

endpackage

// File: rtl/fwd_stall_ctrl_if.sv
// Hazard-unit bundle: pipeline-stage register fields in,
// forward selects, stall controls and MC status out.
interface fwd_stall_ctrl_if #(
  parameter int REG_W = 5
);

  logic [REG_W-1:0] rs1_id;
  logic [REG_W-1:0] rs2_id;
  logic             use_rs1_id;
  logic             use_rs2_id;
  logic             regWrite_id;
  logic             mc_op_id;
  logic [REG_W-1:0] rd_id;

  logic [REG_W-1:0] rs1_ex;
  logic [REG_W-1:0] rs2_ex;
  logic             use_rs1_ex;
  logic             use_rs2_ex;
  logic             store_ex;
  logic [REG_W-1:0] rd_ex;
  logic             regWrite_ex;
  logic             load_ex;
  logic             mc_start_ex;

  logic [REG_W-1:0] rd_mem;
  logic             regWrite_mem;
  logic             load_mem;

  logic [REG_W-1:0] rd_wb;
  logic             regWrite_wb;

  logic [1:0]       fwdA_sel;
  logic [1:0]       fwdB_sel;
  logic [1:0]       fwdS_sel;
  logic             stall_if;
  logic             stall_id;
  logic             bubble_ex;
  logic             mc_busy;
  logic             mc_wb_valid;
  logic [REG_W-1:0] mc_rd;

  modport master (
    output rs1_id, rs2_id, use_rs1_id, use_rs2_id,
    output regWrite_id, mc_op_id, rd_id,
    output rs1_ex, rs2_ex, use_rs1_ex, use_rs2_ex,
    output store_ex, rd_ex, regWrite_ex, load_ex,
    output mc_start_ex,
    output rd_mem, regWrite_mem, load_mem,
    output rd_wb, regWrite_wb,
    input  fwdA_sel, fwdB_sel, fwdS_sel,
    input  stall_if, stall_id, bubble_ex,
    input  mc_busy, mc_wb_valid, mc_rd
  );

  modport slave (
    input  rs1_id, rs2_id, use_rs1_id, use_rs2_id,
    input  regWrite_id, mc_op_id, rd_id,
    input  rs1_ex, rs2_ex, use_rs1_ex, use_rs2_ex,
    input  store_ex, rd_ex, regWrite_ex, load_ex,
    input  mc_start_ex,
    input  rd_mem, regWrite_mem, load_mem,
    input  rd_wb, regWrite_wb,
    output fwdA_sel, fwdB_sel, fwdS_sel,
    output stall_if, stall_id, bubble_ex,
    output mc_busy, mc_wb_valid, mc_rd
  );

endinterface

// File: rtl/fwd_stall_ctrl_fwd_sel.sv
// Per-operand forward select: MEM result beats WB result,
// loads in MEM are not forwardable yet.
module fwd_sel
  import fwd_stall_ctrl_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int FWD_R0 = 0
) (
  input  logic             en_i,
  input  logic [REG_W-1:0] src_i,
  input  logic [REG_W-1:0] rd_mem_i,
  input  logic             rw_mem_i,
  input  logic             ld_mem_i,
  input  logic [REG_W-1:0] rd_wb_i,
  input  logic             rw_wb_i,
  output logic [1:0]       sel_o
);

  function automatic logic match(
    input logic [REG_W-1:0] a,
    input logic [REG_W-1:0] b
  );
    return (a == b) && ((a != '0) || (FWD_R0 != 0));
  endfunction

  logic hit_mem;
  logic hit_wb;

  assign hit_mem = rw_mem_i & ~ld_mem_i & match(rd_mem_i, src_i);
  assign hit_wb  = rw_wb_i & match(rd_wb_i, src_i);

  // Priority pick of the youngest in-flight producer.
  always_comb begin
    sel_o = FWD_RF;
    if (en_i) begin
      if (hit_mem)     sel_o = FWD_MEM;
      else if (hit_wb) sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_stall_ctrl.sv
// Forwarding/stall controller: three forward selects,
// load-use bubbles and a single outstanding MC op tracker.
module fwd_stall_ctrl
  import fwd_stall_ctrl_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int MC_LAT = 4,
  parameter int FWD_R0 = 0
) (
  input logic           clk,
  input logic           reset,
  fwd_stall_ctrl_if.slave bus
);

  localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MC_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  function automatic logic match(
    input logic [REG_W-1:0] a,
    input logic [REG_W-1:0] b
  );
    return (a == b) && ((a != '0) || (FWD_R0 != 0));
  endfunction

  mc_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [REG_W-1:0] rd_q, rd_d;

  logic [1:0] a_sel, b_sel, s_sel;

  fwd_sel #(.REG_W(REG_W), .FWD_R0(FWD_R0)) u_fwd_a (
    .en_i     (bus.use_rs1_ex),
    .src_i    (bus.rs1_ex),
    .rd_mem_i (bus.rd_mem),
    .rw_mem_i (bus.regWrite_mem),
    .ld_mem_i (bus.load_mem),
    .rd_wb_i  (bus.rd_wb),
    .rw_wb_i  (bus.regWrite_wb),
    .sel_o    (a_sel)
  );

  fwd_sel #(.REG_W(REG_W), .FWD_R0(FWD_R0)) u_fwd_b (
    .en_i     (bus.use_rs2_ex & ~bus.store_ex),
    .src_i    (bus.rs2_ex),
    .rd_mem_i (bus.rd_mem),
    .rw_mem_i (bus.regWrite_mem),
    .ld_mem_i (bus.load_mem),
    .rd_wb_i  (bus.rd_wb),
    .rw_wb_i  (bus.regWrite_wb),
    .sel_o    (b_sel)
  );

  fwd_sel #(.REG_W(REG_W), .FWD_R0(FWD_R0)) u_fwd_s (
    .en_i     (bus.store_ex),
    .src_i    (bus.rs2_ex),
    .rd_mem_i (bus.rd_mem),
    .rw_mem_i (bus.regWrite_mem),
    .ld_mem_i (bus.load_mem),
    .rd_wb_i  (bus.rd_wb),
    .rw_wb_i  (bus.regWrite_wb),
    .sel_o    (s_sel)
  );

  // MC tracker state, latency counter and destination.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  // Next state: a start in BUSY is ignored (structural stall
  // keeps it from happening); DONE can chain straight on.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mc_start_ex) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
          rd_d    = bus.rd_ex;
        end
      end
      BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) state_d = DONE;
      end
      DONE: begin
        if (bus.mc_start_ex) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
          rd_d    = bus.rd_ex;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  logic id_raw_mc;
  logic id_waw_mc;
  logic mc_stall;
  logic lu_stall;
  logic stall;

  // Hazard detection against the load in EX and the MC op.
  always_comb begin
    id_raw_mc = (bus.use_rs1_id & match(bus.rs1_id, rd_q))
              | (bus.use_rs2_id & match(bus.rs2_id, rd_q));
    id_waw_mc = bus.regWrite_id & match(bus.rd_id, rd_q);
    lu_stall  = bus.load_ex & bus.regWrite_ex
              & ((bus.use_rs1_id & match(bus.rs1_id, bus.rd_ex))
              |  (bus.use_rs2_id & match(bus.rs2_id, bus.rd_ex)));
    mc_stall  = 1'b0;
    if (state_q == BUSY)
      mc_stall = id_raw_mc | id_waw_mc | bus.mc_op_id;
    else if (state_q == DONE)
      mc_stall = id_waw_mc | bus.mc_op_id;
    stall = ~reset & (lu_stall | mc_stall);
  end

  assign bus.fwdA_sel    = reset ? FWD_RF : a_sel;
  assign bus.fwdB_sel    = reset ? FWD_RF : b_sel;
  assign bus.fwdS_sel    = reset ? FWD_RF : s_sel;
  assign bus.stall_if    = stall;
  assign bus.stall_id    = stall;
  assign bus.bubble_ex   = stall;
  assign bus.mc_busy     = ~reset & (state_q != IDLE);
  assign bus.mc_wb_valid = ~reset & (state_q == DONE);
  assign bus.mc_rd       = reset ? '0 : rd_q;

endmodule

// File: tb/tb_fwd_stall_ctrl.sv
// Self-checking bench for fwd_stall_ctrl: timestamp model
// of the MC unit plus directed hazard vectors.
module tb_fwd_stall_ctrl;

  localparam int RW  = 5;
  localparam int LAT = 4;
  localparam int R0  = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fwd_stall_ctrl_if #(.REG_W(RW)) bus ();

  fwd_stall_ctrl #(
    .REG_W(RW), .MC_LAT(LAT), .FWD_R0(R0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_pass = 0;
  int n_tot  = 0;
  bit run    = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
  endtask

  // Model: MC op timed by the cycle number it was accepted in.
  int cyc = 0;
  int st_cyc = 0;
  bit st_v = 1'b0;
  logic [RW-1:0] m_rd = '0;
  int ph;
  bit m_busy, m_done;

  always_comb begin
    ph     = cyc - st_cyc;
    m_busy = st_v && ph >= 1 && ph <= LAT;
    m_done = st_v && ph == LAT;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc <= 0; st_v <= 1'b0; st_cyc <= 0; m_rd <= '0;
    end else begin
      cyc <= cyc + 1;
      if (bus.mc_start_ex && (!m_busy || m_done)) begin
        st_v <= 1'b1; st_cyc <= cyc; m_rd <= bus.rd_ex;
      end
    end
  end

  function automatic bit mt(input logic [RW-1:0] a, input logic [RW-1:0] b);
    return a == b && (a != 0 || R0 != 0);
  endfunction

  function automatic int fsel(input bit u, input logic [RW-1:0] s);
    if (!u) return 0;
    if (bus.regWrite_mem && !bus.load_mem && mt(bus.rd_mem, s)) return 1;
    if (bus.regWrite_wb && mt(bus.rd_wb, s)) return 2;
    return 0;
  endfunction

  function automatic int e_fa();
    return reset ? 0 : fsel(bus.use_rs1_ex, bus.rs1_ex);
  endfunction

  function automatic int e_fb();
    return (reset || bus.store_ex) ? 0 : fsel(bus.use_rs2_ex, bus.rs2_ex);
  endfunction

  function automatic int e_fs();
    return (reset || !bus.store_ex) ? 0 : fsel(1'b1, bus.rs2_ex);
  endfunction

  function automatic int e_stall();
    bit lu, raw, waw, mc;
    if (reset) return 0;
    lu  = bus.load_ex && bus.regWrite_ex &&
          ((bus.use_rs1_id && mt(bus.rs1_id, bus.rd_ex)) ||
           (bus.use_rs2_id && mt(bus.rs2_id, bus.rd_ex)));
    raw = (bus.use_rs1_id && mt(bus.rs1_id, m_rd)) ||
          (bus.use_rs2_id && mt(bus.rs2_id, m_rd));
    waw = bus.regWrite_id && mt(bus.rd_id, m_rd);
    mc  = (m_busy && !m_done && (raw || waw || bus.mc_op_id)) ||
          (m_done && (waw || bus.mc_op_id));
    return int'(lu || mc);
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (run) begin
      chk("fwdA", int'(bus.fwdA_sel), e_fa());
      chk("fwdB", int'(bus.fwdB_sel), e_fb());
      chk("fwdS", int'(bus.fwdS_sel), e_fs());
      chk("stall_if", int'(bus.stall_if), e_stall());
      chk("stall_id", int'(bus.stall_id), e_stall());
      chk("bubble_ex", int'(bus.bubble_ex), e_stall());
      chk("mc_busy", int'(bus.mc_busy), reset ? 0 : int'(m_busy));
      chk("mc_wb_valid", int'(bus.mc_wb_valid), reset ? 0 : int'(m_done));
      chk("mc_rd", int'(bus.mc_rd), reset ? 0 : int'(m_rd));
    end
  end

  task automatic clr();
    bus.rs1_id = '0; bus.rs2_id = '0; bus.rd_id = '0;
    bus.use_rs1_id = 0; bus.use_rs2_id = 0;
    bus.regWrite_id = 0; bus.mc_op_id = 0;
    bus.rs1_ex = '0; bus.rs2_ex = '0; bus.rd_ex = '0;
    bus.use_rs1_ex = 0; bus.use_rs2_ex = 0; bus.store_ex = 0;
    bus.regWrite_ex = 0; bus.load_ex = 0; bus.mc_start_ex = 0;
    bus.rd_mem = '0; bus.regWrite_mem = 0; bus.load_mem = 0;
    bus.rd_wb = '0; bus.regWrite_wb = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  initial begin
    clr();
    bus.rs1_ex = 3; bus.use_rs1_ex = 1;
    bus.rd_mem = 3; bus.regWrite_mem = 1;
    bus.rd_wb = 3; bus.regWrite_wb = 1;
    bus.mc_op_id = 1;
    run = 1'b1;
    mid();
    chk("rst_fwdA", int'(bus.fwdA_sel), 0);
    chk("rst_stall", int'(bus.stall_if), 0);
    chk("rst_busy", int'(bus.mc_busy), 0);

    step(); reset = 1'b0; bus.mc_op_id = 0;
    mid(); chk("lit_fwdA_mem", int'(bus.fwdA_sel), 1);
    step(); bus.load_mem = 1;
    mid(); chk("lit_fwdA_wb", int'(bus.fwdA_sel), 2);
    step();
    bus.rs1_ex = 0; bus.rd_mem = 0; bus.rd_wb = 0; bus.load_mem = 0;
    mid(); chk("lit_fwdA_r0", int'(bus.fwdA_sel), 0);

    step(); clr();
    bus.store_ex = 1; bus.rs2_ex = 4; bus.use_rs2_ex = 1;
    bus.rd_wb = 4; bus.regWrite_wb = 1;
    mid();
    chk("lit_fwdS_wb", int'(bus.fwdS_sel), 2);
    chk("lit_fwdB_st", int'(bus.fwdB_sel), 0);
    step(); bus.store_ex = 0;
    mid();
    chk("lit_fwdB_wb", int'(bus.fwdB_sel), 2);
    chk("lit_fwdS_nost", int'(bus.fwdS_sel), 0);

    step(); clr();
    bus.load_ex = 1; bus.regWrite_ex = 1; bus.rd_ex = 7;
    bus.rs2_id = 7; bus.use_rs2_id = 1;
    mid(); chk("lit_lu_stall", int'(bus.bubble_ex), 1);
    step();
    bus.load_ex = 0; bus.regWrite_ex = 0; bus.rd_ex = 0;
    bus.rd_mem = 7; bus.regWrite_mem = 1; bus.load_mem = 1;
    mid(); chk("lit_lu_release", int'(bus.stall_if), 0);
    step(); clr();
    bus.load_ex = 1; bus.regWrite_ex = 1; bus.rd_ex = 0;
    bus.rs2_id = 0; bus.use_rs2_id = 1;
    mid(); chk("lit_lu_r0", int'(bus.stall_id), 0);

    step(); clr();
    bus.mc_start_ex = 1; bus.rd_ex = 9; bus.regWrite_ex = 1;
    bus.rs1_id = 9; bus.use_rs1_id = 1;
    mid(); chk("lit_mc_start_nostall", int'(bus.stall_if), 0);
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 1) begin
        bus.mc_start_ex = 0; bus.rd_ex = 0; bus.regWrite_ex = 0;
      end
      mid();
      chk("lit_mc_raw_stall", int'(bus.stall_if), (i <= 3) ? 1 : 0);
      chk("lit_mc_wbv", int'(bus.mc_wb_valid), (i == 4) ? 1 : 0);
      chk("lit_mc_busy", int'(bus.mc_busy), (i <= 4) ? 1 : 0);
    end

    step(); clr();
    bus.mc_start_ex = 1; bus.rd_ex = 10; bus.regWrite_ex = 1;
    for (int i = 1; i <= 9; i++) begin
      step();
      if (i == 1) begin
        bus.mc_start_ex = 0; bus.rd_ex = 0; bus.regWrite_ex = 0;
        bus.mc_op_id = 1; bus.rs1_id = 2; bus.use_rs1_id = 1;
      end
      if (i == 4) begin
        bus.mc_start_ex = 1; bus.rd_ex = 11; bus.regWrite_ex = 1;
      end
      if (i == 5) begin
        bus.mc_start_ex = 0; bus.rd_ex = 0; bus.regWrite_ex = 0;
        bus.mc_op_id = 0;
      end
      mid();
      if (i <= 4) chk("lit_struct_stall", int'(bus.stall_id), 1);
      if (i == 5) begin
        chk("lit_b2b_busy", int'(bus.mc_busy), 1);
        chk("lit_b2b_rd", int'(bus.mc_rd), 11);
      end
      if (i == 8) chk("lit_b2b_wbv", int'(bus.mc_wb_valid), 1);
    end

    step(); clr();
    bus.mc_start_ex = 1; bus.rd_ex = 13; bus.regWrite_ex = 1;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 1) begin
        bus.mc_start_ex = 0; bus.rd_ex = 0; bus.regWrite_ex = 0;
        bus.regWrite_id = 1; bus.rd_id = 13;
      end
      mid();
      chk("lit_waw_stall", int'(bus.stall_if), (i <= 4) ? 1 : 0);
    end

    step(); clr();
    bus.mc_start_ex = 1; bus.rd_ex = 12; bus.regWrite_ex = 1;
    step(); bus.mc_start_ex = 0; bus.rd_ex = 0; bus.regWrite_ex = 0;
    step();
    reset = 1'b1;
    bus.rs1_ex = 3; bus.use_rs1_ex = 1;
    bus.rd_wb = 3; bus.regWrite_wb = 1; bus.mc_op_id = 1;
    #1;
    chk("lit_rst_busy", int'(bus.mc_busy), 0);
    chk("lit_rst_rd", int'(bus.mc_rd), 0);
    chk("lit_rst_fwdA", int'(bus.fwdA_sel), 0);
    chk("lit_rst_stall", int'(bus.stall_if), 0);
    step(); step();
    reset = 1'b0; clr();
    for (int i = 1; i <= 6; i++) begin
      mid();
      chk("lit_rst_nowbv", int'(bus.mc_wb_valid), 0);
      chk("lit_rst_idle", int'(bus.mc_busy), 0);
      step();
    end

    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
